game_timer: RTL

//  Parametrised successor to the fixed 25-cycle round timer.

---
 rtl/game_timer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/game_timer.sv
// Programmable prescaled countdown timer with one-shot/periodic modes, restart and abort.
// Optional registered warn output is compiled in with GAME_TIMER_WARN_EN.
module game_timer #(
  parameter int CLK_DIV = 25,
  parameter int CNT_W   = 8
`ifdef GAME_TIMER_WARN_EN
  ,
  parameter int WARN_THRESH = 3
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             timerout,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic             per_q, per_d;
  logic             tick_q, tick_d;
  logic             tout_q, tout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ps_q    <= '0;
      rem_q   <= '0;
      load_q  <= '0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      rem_q   <= rem_d;
      load_q  <= load_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    rem_d   = rem_q;
    load_d  = load_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    tout_d  = 1'b0;
    if (start) begin
      load_d = load_val;
      per_d  = periodic;
      ps_d   = '0;
      if (load_val != '0) begin
        state_d = RUN;
        rem_d   = load_val;
      end else begin
        // A zero-length run expires immediately without entering RUN.
        state_d = IDLE;
        rem_d   = '0;
        tout_d  = 1'b1;
      end
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        rem_d   = '0;
        ps_d    = '0;
      end
    end else if (state_q == RUN && en) begin
      if (ps_q == PS_MAX) begin
        ps_d   = '0;
        tick_d = 1'b1;
        if (rem_q <= CNT_W'(1)) begin
          tout_d = 1'b1;
          if (per_q) begin
            rem_d = load_q;
          end else begin
            rem_d   = '0;
            state_d = IDLE;
          end
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  assign timerout  = tout_q;
  assign tick      = tick_q;
  assign busy      = (state_q == RUN);
  assign remaining = rem_q;

`ifdef GAME_TIMER_WARN_EN
  localparam logic [CNT_W:0] WARN_T = (CNT_W + 1)'(WARN_THRESH);

  logic warn_q, warn_d;

  // Derived from next state so warn lines up with the remaining value it describes.
  always_comb begin
    warn_d = (state_d == RUN) && (rem_d != '0) && ({1'b0, rem_d} <= WARN_T);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warn_q <= 1'b0;
    else          warn_q <= warn_d;
  end

  assign warn = warn_q;
`endif

endmodule
